// File: rtl/reduce_engine_pkg.sv
// Shared types and constants for the reduce engine.
//   ADDR_WIDTH / DATA_WIDTH / TAG_WIDTH : default bus widths
//   reduce_state_t                      : engine FSM state encoding
//   port_bits()                         : width of a port index (at least 1)
package reduce_engine_pkg;

    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_WIDTH  = 4;

    typedef enum logic [1:0] {
        RED_IDLE   = 2'd0,
        RED_ACTIVE = 2'd1,
        RED_DONE   = 2'd2
    } reduce_state_t;

    function automatic int port_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/reduce_engine_if.sv
// Bundle of all reduce engine signals.
//   req_*            : request from the command decoder
//   mem_rd_*         : per-port read issue and read response channels
//   reduce_*         : one-cycle completion report
//   busy / dbg_state : engine activity and current FSM state
// Handshakes: a request is taken on a cycle with req_valid && req_ready.
// A read is issued on port i on a cycle with mem_rd_valid[i] && mem_rd_ready[i];
// once raised, mem_rd_valid[i] holds until that cycle. Responses and
// reduce_done are plain valid strobes with no back-pressure.
// Modports: slave = engine side, master = decoder/memory side.
interface reduce_engine_if #(
    parameter int NUM_PORTS  = 4,
    parameter int ADDR_WIDTH = reduce_engine_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = reduce_engine_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH  = reduce_engine_pkg::TAG_WIDTH
);
    import reduce_engine_pkg::*;

    localparam int PORT_BITS = port_bits(NUM_PORTS);

    logic                                  req_valid;
    logic [NUM_PORTS-1:0]                  req_mask;
    logic [ADDR_WIDTH-1:0]                 req_addr;
    logic [TAG_WIDTH-1:0]                  req_tag;
    logic [PORT_BITS-1:0]                  req_src_port;
    logic                                  req_ready;

    logic [NUM_PORTS-1:0]                  mem_rd_valid;
    logic [ADDR_WIDTH-1:0]                 mem_rd_addr;
    logic [NUM_PORTS-1:0]                  mem_rd_ready;
    logic [NUM_PORTS-1:0]                  mem_rd_resp_valid;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  mem_rd_resp_data;

    logic                                  reduce_done;
    logic [DATA_WIDTH-1:0]                 reduce_result;
    logic [TAG_WIDTH-1:0]                  reduce_tag;
    logic [PORT_BITS-1:0]                  reduce_dst_port;
    logic                                  reduce_error;
    logic                                  busy;
    reduce_state_t                         dbg_state;

    modport slave (
        input  req_valid, req_mask, req_addr, req_tag, req_src_port,
        output req_ready,
        output mem_rd_valid, mem_rd_addr,
        input  mem_rd_ready, mem_rd_resp_valid, mem_rd_resp_data,
        output reduce_done, reduce_result, reduce_tag, reduce_dst_port, reduce_error,
        output busy, dbg_state
    );

    modport master (
        output req_valid, req_mask, req_addr, req_tag, req_src_port,
        input  req_ready,
        input  mem_rd_valid, mem_rd_addr,
        output mem_rd_ready, mem_rd_resp_valid, mem_rd_resp_data,
        input  reduce_done, reduce_result, reduce_tag, reduce_dst_port, reduce_error,
        input  busy, dbg_state
    );

endinterface

// File: rtl/reduce_engine_adder_tree.sv
// reduce_adder_tree: combinational sum of the words whose mask bit is set.
//   data : NUM_PORTS words
//   mask : selects which words contribute
//   sum  : wrapped (mod 2^DATA_WIDTH) total of the selected words
module reduce_adder_tree #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] data,
    input  logic [NUM_PORTS-1:0]                 mask,
    output logic [DATA_WIDTH-1:0]                sum
);

    // Written as a chain; synthesis is free to rebalance it into a tree.
    always_comb begin
        sum = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (mask[i]) begin
                sum = sum + data[i];
            end
        end
    end

endmodule

// File: rtl/reduce_engine.sv
// reduce_engine: fans one read out to every member port, sums the returned
// words (wrapping) and reports result, tag and requester with a one-cycle
// reduce_done pulse. A request that has not fully completed within
// TIMEOUT_CYCLES active cycles finishes with reduce_error and the partial sum.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : reduce_engine_if.slave (request, memory read, completion,
//              busy and debug state)
module reduce_engine #(
    parameter int NUM_PORTS      = 4,
    parameter int ADDR_WIDTH     = reduce_engine_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH     = reduce_engine_pkg::DATA_WIDTH,
    parameter int TAG_WIDTH      = reduce_engine_pkg::TAG_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            rst,
    reduce_engine_if.slave  bus
);
    import reduce_engine_pkg::*;

    localparam int PORT_BITS = port_bits(NUM_PORTS);
    localparam int CNT_BITS  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);

    reduce_state_t          state;
    logic [NUM_PORTS-1:0]   issue_pend;
    logic [NUM_PORTS-1:0]   resp_pend;
    logic [DATA_WIDTH-1:0]  acc;
    logic [CNT_BITS-1:0]    tmo_cnt;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic [PORT_BITS-1:0]   src_q;

    logic                   done_q;
    logic [DATA_WIDTH-1:0]  result_q;
    logic [TAG_WIDTH-1:0]   rtag_q;
    logic [PORT_BITS-1:0]   dst_q;
    logic                   err_q;

    // Pending masks are zero outside RED_ACTIVE, so these are too.
    logic [NUM_PORTS-1:0]   issue_take;
    logic [NUM_PORTS-1:0]   resp_take;
    logic [NUM_PORTS-1:0]   issue_left;
    logic [NUM_PORTS-1:0]   resp_left;
    logic [DATA_WIDTH-1:0]  resp_sum;
    logic [DATA_WIDTH-1:0]  acc_next;
    logic                   all_clear;
    logic                   timeout_hit;

    assign issue_take  = issue_pend & bus.mem_rd_ready;
    assign resp_take   = resp_pend & bus.mem_rd_resp_valid;
    assign issue_left  = issue_pend & ~issue_take;
    assign resp_left   = resp_pend & ~resp_take;
    assign acc_next    = acc + resp_sum;
    assign all_clear   = (issue_left == '0) && (resp_left == '0);
    assign timeout_hit = (tmo_cnt == TMO_LAST);

    reduce_adder_tree #(
        .NUM_PORTS  (NUM_PORTS),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_adder (
        .data (bus.mem_rd_resp_data),
        .mask (resp_take),
        .sum  (resp_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RED_IDLE;
            issue_pend <= '0;
            resp_pend  <= '0;
            acc        <= '0;
            tmo_cnt    <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            src_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            rtag_q     <= '0;
            dst_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                RED_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q     <= bus.req_addr;
                        tag_q      <= bus.req_tag;
                        src_q      <= bus.req_src_port;
                        issue_pend <= bus.req_mask;
                        resp_pend  <= bus.req_mask;
                        acc        <= '0;
                        tmo_cnt    <= '0;
                        state      <= RED_ACTIVE;
                    end
                end
                RED_ACTIVE: begin
                    acc        <= acc_next;
                    tmo_cnt    <= tmo_cnt + 1'b1;
                    issue_pend <= issue_left;
                    resp_pend  <= resp_left;
                    // Normal completion wins over a timeout landing on the same cycle.
                    if (all_clear || timeout_hit) begin
                        issue_pend <= '0;
                        resp_pend  <= '0;
                        done_q     <= 1'b1;
                        result_q   <= acc_next;
                        rtag_q     <= tag_q;
                        dst_q      <= src_q;
                        err_q      <= !all_clear;
                        state      <= RED_DONE;
                    end
                end
                RED_DONE: begin
                    done_q <= 1'b0;
                    state  <= RED_IDLE;
                end
                default: begin
                    state <= RED_IDLE;
                end
            endcase
        end
    end

    // Ready is masked during reset so every output reads 0 while rst is high.
    assign bus.req_ready       = (state == RED_IDLE) && !rst;
    assign bus.mem_rd_valid    = issue_pend;
    assign bus.mem_rd_addr     = addr_q;
    assign bus.reduce_done     = done_q;
    assign bus.reduce_result   = result_q;
    assign bus.reduce_tag      = rtag_q;
    assign bus.reduce_dst_port = dst_q;
    assign bus.reduce_error    = err_q;
    assign bus.busy            = (state != RED_IDLE);
    assign bus.dbg_state       = state;

endmodule

// File: tb/tb_reduce_engine.sv
module tb_reduce_engine;

    localparam int NP  = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TW  = 4;
    localparam int PB  = 2;
    localparam int TMO = 16;
    localparam logic [7:0] NEVER = 8'hFF;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reduce_engine_if #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

    reduce_engine #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct packed {
        logic [NP-1:0]          mask;
        logic [NP-1:0][DW-1:0]  data;
        logic [NP-1:0][3:0]     rd_delay;    // stall cycles before ready
        logic [NP-1:0][7:0]     resp_delay;  // cycles after issue; NEVER = no response
        logic [NP-1:0]          stray;       // unsolicited responses in the first active cycle
        logic [DW-1:0]          stray_data;
        logic [DW-1:0]          exp_result;
        logic                   exp_err;
        int                     exp_done;    // cycles after accept
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [NP-1:0] mask, input logic [NP-1:0][DW-1:0] data,
                                input logic [NP-1:0][3:0] rd, input logic [NP-1:0][7:0] rsp,
                                input logic [NP-1:0] stray, input logic [DW-1:0] sdata,
                                input logic [DW-1:0] res, input logic err, input int dn);
        vec_t v;
        v.mask = mask; v.data = data; v.rd_delay = rd; v.resp_delay = rsp;
        v.stray = stray; v.stray_data = sdata;
        v.exp_result = res; v.exp_err = err; v.exp_done = dn;
        return v;
    endfunction

    // Reference: port i responds on active cycle 1+rd+resp. All in by TMO -> done one
    // cycle after the last; otherwise done after TMO active cycles with the partial sum.
    function automatic vec_t model(input vec_t v);
        vec_t o = v;
        int last = 1;
        bit never = 0;
        logic [DW-1:0] part = '0;
        for (int i = 0; i < NP; i++) begin
            if (v.mask[i]) begin
                if (v.resp_delay[i] == NEVER) never = 1;
                else begin
                    int rc = 1 + int'(v.rd_delay[i]) + int'(v.resp_delay[i]);
                    if (rc > last) last = rc;
                    if (rc <= TMO) part = part + v.data[i];
                end
            end
        end
        o.exp_result = part;
        if (!never && last <= TMO) begin
            o.exp_err = 1'b0; o.exp_done = last + 1;
        end else begin
            o.exp_err = 1'b1; o.exp_done = TMO + 1;
        end
        return o;
    endfunction

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.req_valid = 1'b0; bus.req_mask = '0; bus.req_addr = '0;
        bus.req_tag = '0; bus.req_src_port = '0;
        bus.mem_rd_ready = '0; bus.mem_rd_resp_valid = '0; bus.mem_rd_resp_data = '0;
    endtask

    // Called at a negedge with the engine idle; returns at the negedge after done.
    task automatic run_vec(input string name, input vec_t v, input logic [TW-1:0] tag,
                           input logic [PB-1:0] src, input logic [AW-1:0] addr);
        int cyc = 1;
        int dc = -1;
        int stall[NP];
        int iss[NP];
        int vcnt[NP];
        bit addr_ok = 1;
        logic [DW-1:0] r = '0;
        logic e = 1'b0;
        logic [TW-1:0] t = '0;
        logic [PB-1:0] d = '0;
        logic [NP-1:0] rdy, rv;
        logic [NP-1:0][DW-1:0] rdat;
        for (int i = 0; i < NP; i++) begin stall[i] = 0; iss[i] = -1; vcnt[i] = 0; end
        check({name, ".req_ready"}, bus.req_ready, 1);
        bus.req_valid = 1'b1; bus.req_mask = v.mask; bus.req_addr = addr;
        bus.req_tag = tag; bus.req_src_port = src;
        exp_q.push_back(v.exp_result);
        @(negedge clk);
        bus.req_valid = 1'b0;
        while (dc < 0 && cyc < 60) begin
            rdy = '0; rv = '0; rdat = '0;
            if (bus.reduce_done) begin
                dc = cyc; r = bus.reduce_result; e = bus.reduce_error;
                t = bus.reduce_tag; d = bus.reduce_dst_port;
            end else begin
                for (int i = 0; i < NP; i++) begin
                    if (bus.mem_rd_valid[i]) begin
                        vcnt[i]++;
                        if (bus.mem_rd_addr !== addr) addr_ok = 0;
                        if (stall[i] >= int'(v.rd_delay[i])) begin rdy[i] = 1'b1; iss[i] = cyc; end
                        else stall[i]++;
                    end
                    if (iss[i] >= 0 && v.resp_delay[i] != NEVER && cyc == iss[i] + int'(v.resp_delay[i])) begin
                        rv[i] = 1'b1; rdat[i] = v.data[i];
                    end
                    if (v.stray[i] && cyc == 1) begin rv[i] = 1'b1; rdat[i] = v.stray_data; end
                end
            end
            bus.mem_rd_ready = rdy; bus.mem_rd_resp_valid = rv; bus.mem_rd_resp_data = rdat;
            if (dc < 0) begin
                @(negedge clk);
                cyc++;
            end
        end
        check({name, ".done_cycle"}, dc, v.exp_done);
        if (exp_q.size() > 0) check({name, ".result"}, r, exp_q.pop_front());
        check({name, ".tag"}, t, tag);
        check({name, ".dst"}, d, src);
        check({name, ".error"}, e, v.exp_err);
        check({name, ".rd_addr"}, addr_ok, 1);
        for (int i = 0; i < NP; i++) begin
            int ev = 0;
            if (v.mask[i]) ev = (int'(v.rd_delay[i]) + 1 < v.exp_done - 1) ? int'(v.rd_delay[i]) + 1 : v.exp_done - 1;
            check($sformatf("%s.valid_cycles%0d", name, i), vcnt[i], ev);
        end
        @(negedge clk);
        check({name, ".done_single"}, bus.reduce_done, 0);
        check({name, ".busy_after"}, bus.busy, 0);
        check({name, ".result_hold"}, bus.reduce_result, v.exp_result);
    endtask

    // ---------------- test ----------------
    vec_t vecs[5];

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        idle_inputs();
        rst = 1'b1;

        vecs[0] = mk(4'b1111, {32'd4, 32'd3, 32'd2, 32'd1}, '0, {8'd1, 8'd1, 8'd1, 8'd1},
                     4'b0000, 32'd0, 32'd10, 1'b0, 3);
        vecs[1] = mk(4'b0101, {32'd0, 32'd2, 32'd0, 32'hFFFF_FFFF}, {4'd0, 4'd3, 4'd0, 4'd0},
                     {8'd1, 8'd1, 8'd1, 8'd1}, 4'b0000, 32'd0, 32'd1, 1'b0, 6);
        vecs[2] = mk(4'b0000, '0, '0, '0, 4'b0000, 32'd0, 32'd0, 1'b0, 2);
        vecs[3] = mk(4'b0010, {32'd0, 32'd0, 32'd5, 32'd0}, '0, {8'd1, 8'd1, 8'd1, 8'd1},
                     4'b1000, 32'd7, 32'd5, 1'b0, 3);
        vecs[4] = mk(4'b0011, {32'd0, 32'd0, 32'd9, 32'h1234}, '0, {8'd1, 8'd1, NEVER, 8'd1},
                     4'b0000, 32'd0, 32'h1234, 1'b1, TMO + 1);

        repeat (2) @(negedge clk);
        check("reset.req_ready", bus.req_ready, 0);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.reduce_done, 0);
        check("reset.result", bus.reduce_result, 0);
        check("reset.rd_valid", bus.mem_rd_valid, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 5; k++)
            run_vec($sformatf("dir%0d", k), vecs[k], TW'(k + 3), PB'(k), 32'h100 + AW'(k));

        // Reset in RED_ACTIVE after both reads were issued.
        bus.req_valid = 1'b1; bus.req_mask = 4'b0011; bus.req_addr = 32'h200;
        bus.req_tag = 4'd9; bus.req_src_port = 2'd1;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.mem_rd_ready = 4'b0011;
        bus.mem_rd_resp_valid = 4'b0001; bus.mem_rd_resp_data = {32'd0, 32'd0, 32'd0, 32'd77};
        @(negedge clk);
        check("midrst.issued", bus.mem_rd_valid, 0);
        check("midrst.busy_before", bus.busy, 1);
        idle_inputs();
        rst = 1'b1;
        #1;
        check("midrst.busy", bus.busy, 0);
        check("midrst.result_cleared", bus.reduce_result, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("midrst.no_done", bus.reduce_done, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst.idle_after", bus.busy, 0);
        run_vec("after_rst", vecs[0], 4'd11, 2'd3, 32'h300);

        // Randomised transactions, back-to-back, checked against the model.
        for (int n = 0; n < 24; n++) begin
            v.mask = NP'($urandom_range(0, 15));
            v.stray_data = $urandom;
            v.stray = ~v.mask & NP'($urandom_range(0, 15));
            for (int i = 0; i < NP; i++) begin
                v.data[i] = $urandom;
                v.rd_delay[i] = 4'($urandom_range(0, 3));
                v.resp_delay[i] = ($urandom_range(0, 7) == 0) ? NEVER : 8'($urandom_range(0, 4));
            end
            v = model(v);
            run_vec($sformatf("rnd%0d", n), v, TW'($urandom), PB'($urandom), AW'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
